// File: rtl/smm_feeder.sv
// Operand issuer / result collector for the Strassen 2x2 block multiplier.
// Optional zero-operand skip enabled by defining SMM_FEEDER_ZEROSKIP_EN.
module smm_feeder #(
   parameter int unsigned DATAWIDTH  = 128,
   parameter int unsigned BLOCKSIZE  = 32,
   parameter int unsigned RESULT_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BLOCKSIZE-1:0] in_data,
   input  logic                 in_mode,
   output logic [DATAWIDTH-1:0] A,
   output logic [DATAWIDTH-1:0] B,
   output logic                 load,
   output logic                 sel,
   input  logic [DATAWIDTH-1:0] C_in,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [DATAWIDTH-1:0] res_data,
   output logic                 res_mode,
   output logic                 busy
);

   localparam int unsigned WCW = (RESULT_LAT < 2) ? 1 : $clog2(RESULT_LAT + 1);

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, HOLD} state_e;

   state_e               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [WCW-1:0]       wcnt_q, wcnt_d;
   logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
   logic                 sel_q, sel_d;
   logic                 in_ready_q, in_ready_d;
   logic                 load_q, load_d;
   logic                 res_valid_q, res_valid_d;
   logic                 busy_q, busy_d;
   logic                 accept;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wcnt_d     = wcnt_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      res_data_d = res_data_q;
      accept     = in_valid && in_ready_q;

      case (state_q)
         FILL: begin
            if (accept) begin
               for (int unsigned k = 0; k < 4; k++) begin
                  if (cnt_q[1:0] == 2'(k)) begin
                     if (cnt_q[2]) b_d[k*BLOCKSIZE +: BLOCKSIZE] = in_data;
                     else          a_d[k*BLOCKSIZE +: BLOCKSIZE] = in_data;
                  end
               end
               if (cnt_q == 3'd0) sel_d = in_mode;
               if (cnt_q == 3'd7) begin
                  cnt_d   = 3'd0;
                  state_d = ISSUE;
`ifdef SMM_FEEDER_ZEROSKIP_EN
                  // A zero operand block makes the product zero; skip the multiplier
                  if ((a_d == '0) || (b_d == '0)) begin
                     state_d    = HOLD;
                     res_data_d = '0;
                  end
`endif
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wcnt_d  = WCW'(RESULT_LAT);
         end
         WAIT: begin
            wcnt_d = wcnt_q - WCW'(1);
            if (wcnt_q == WCW'(1)) begin
               res_data_d = C_in;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (res_valid_q && res_ready) state_d = FILL;
         end
         default: state_d = FILL;
      endcase

      in_ready_d  = (state_d == FILL);
      load_d      = (state_d == ISSUE);
      res_valid_d = (state_d == HOLD);
      busy_d      = !((state_d == FILL) && (cnt_d == 3'd0));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= 1'b0;
         res_data_q  <= '0;
         in_ready_q  <= 1'b0;
         load_q      <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         res_data_q  <= res_data_d;
         in_ready_q  <= in_ready_d;
         load_q      <= load_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign A         = a_q;
   assign B         = b_q;
   assign load      = load_q;
   assign sel       = sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_mode  = sel_q;
   assign busy      = busy_q;

endmodule
